control_sequencer: RTL and testbench

//  Hardwired control unit for the phase datapath. Drives every strobe the datapath takes: register
//  out/in selects, MAR/MDR/IR/Y/Z/PC/HI/LO enables, Read, IncrementPC, ALUControl.

---
 rtl/control_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the phase datapath (three-register ALU, MUL/DIV, HALT).
// Optional CU_SINGLE_STEP_EN adds a Step input and a PAUSE state at every instruction boundary.
module control_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int OPC_W    = 5
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [31:0]         IR,
    input  logic                Mem_ready,
    input  logic                Stop,
`ifdef CU_SINGLE_STEP_EN
    input  logic                Step,
`endif
    output logic                PCout,
    output logic                MARin,
    output logic                Zin,
    output logic                ZLOout,
    output logic                ZHIout,
    output logic                PCin,
    output logic                IncrementPC,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                LOin,
    output logic                HIin,
    output logic [OPC_W-1:0]    ALUControl,
    output logic [NUM_REGS-1:0] Rout_sel,
    output logic [NUM_REGS-1:0] Rin_sel,
    output logic                Run,
    output logic                Illegal,
    output logic [3:0]          dbg_state
);

    typedef enum logic [3:0] {
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
`ifdef CU_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t state;
    state_t next_state;
    state_t out_state;
    state_t boundary_state;
    logic   active;

    logic [OPC_W-1:0] opcode;
    logic [3:0]       ra;
    logic [3:0]       rb;
    logic [3:0]       rc;
    logic             is_alu;
    logic             is_muldiv;
    logic             is_halt;
    logic             unused_ir;

    assign opcode    = IR[31 -: OPC_W];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    assign is_alu    = (opcode <= OPC_W'(11));
    assign is_muldiv = (opcode == OPC_W'(12)) || (opcode == OPC_W'(13));
    assign is_halt   = (opcode == OPC_W'(27));

    function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

    // The first edge after reset release only arms 'active'; state stays T0 so
    // that edge is the one that makes T0 visible.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= S_T0;
            active <= 1'b0;
        end else begin
            active <= 1'b1;
            if (active) begin
                state <= next_state;
            end
        end
    end

    assign dbg_state = state;

`ifdef CU_SINGLE_STEP_EN
    assign boundary_state = Stop ? S_HALT : S_PAUSE;
`else
    assign boundary_state = Stop ? S_HALT : S_T0;
`endif

    // Until armed, decode as HALT so every output (Run included) is 0.
    assign out_state = active ? state : S_HALT;

    always_comb begin
        next_state  = state;
        PCout       = 1'b0;
        MARin       = 1'b0;
        Zin         = 1'b0;
        ZLOout      = 1'b0;
        ZHIout      = 1'b0;
        PCin        = 1'b0;
        IncrementPC = 1'b0;
        Read        = 1'b0;
        MDRin       = 1'b0;
        MDRout      = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        LOin        = 1'b0;
        HIin        = 1'b0;
        ALUControl  = '0;
        Rout_sel    = '0;
        Rin_sel     = '0;
        Run         = 1'b0;
        Illegal     = 1'b0;
        case (out_state)
            S_T0: begin
                Run         = 1'b1;
                PCout       = 1'b1;
                MARin       = 1'b1;
                IncrementPC = 1'b1;
                Zin         = 1'b1;
                next_state  = S_T1;
            end
            S_T1: begin
                Run    = 1'b1;
                ZLOout = 1'b1;
                PCin   = 1'b1;
                Read   = 1'b1;
                MDRin  = 1'b1;
                if (Mem_ready) begin
                    next_state = S_T2;
                end
            end
            S_T2: begin
                Run        = 1'b1;
                MDRout     = 1'b1;
                IRin       = 1'b1;
                next_state = S_T3;
            end
            S_T3: begin
                Run      = 1'b1;
                Rout_sel = onehot(rb);
                Yin      = 1'b1;
                if (is_alu || is_muldiv) begin
                    next_state = S_T4;
                end else if (is_halt) begin
                    next_state = S_HALT;
                end else begin
                    Illegal    = 1'b1;
                    next_state = S_T0;
                end
            end
            S_T4: begin
                Run        = 1'b1;
                Rout_sel   = onehot(rc);
                ALUControl = opcode;
                Zin        = 1'b1;
                next_state = S_T5;
            end
            S_T5: begin
                Run    = 1'b1;
                ZLOout = 1'b1;
                if (is_muldiv) begin
                    LOin       = 1'b1;
                    next_state = S_T6;
                end else begin
                    Rin_sel    = onehot(ra);
                    next_state = boundary_state;
                end
            end
            S_T6: begin
                Run        = 1'b1;
                ZHIout     = 1'b1;
                HIin       = 1'b1;
                next_state = boundary_state;
            end
`ifdef CU_SINGLE_STEP_EN
            S_PAUSE: begin
                Run = 1'b1;
                if (Stop) begin
                    next_state = S_HALT;
                end else if (Step) begin
                    next_state = S_T0;
                end
            end
`endif
            default: begin
                next_state = S_HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: the driver queues the expected output
// word for each cycle, the monitor pops and compares at the falling edge.
module tb_control_sequencer;

    logic        Clock;
    logic        Reset;
    logic [31:0] IR;
    logic        Mem_ready;
    logic        Stop;
    logic        step;
    logic        PCout, MARin, Zin, ZLOout, ZHIout, PCin, IncrementPC, Read;
    logic        MDRin, MDRout, IRin, Yin, LOin, HIin;
    logic [4:0]  ALUControl;
    logic [15:0] Rout_sel;
    logic [15:0] Rin_sel;
    logic        Run;
    logic        Illegal;
    logic [3:0]  dbg_state;

    control_sequencer #(.NUM_REGS(16), .OPC_W(5)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
`ifdef CU_SINGLE_STEP_EN
        .Step(step),
`endif
        .PCout(PCout), .MARin(MARin), .Zin(Zin), .ZLOout(ZLOout), .ZHIout(ZHIout),
        .PCin(PCin), .IncrementPC(IncrementPC), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin),
        .ALUControl(ALUControl), .Rout_sel(Rout_sel), .Rin_sel(Rin_sel),
        .Run(Run), .Illegal(Illegal), .dbg_state(dbg_state)
    );

    localparam int W = 53;
    localparam logic [13:0] PCOUT  = 14'h2000;
    localparam logic [13:0] MARIN  = 14'h1000;
    localparam logic [13:0] ZIN    = 14'h0800;
    localparam logic [13:0] ZLOOUT = 14'h0400;
    localparam logic [13:0] ZHIOUT = 14'h0200;
    localparam logic [13:0] PCIN   = 14'h0100;
    localparam logic [13:0] INCPC  = 14'h0080;
    localparam logic [13:0] READ   = 14'h0040;
    localparam logic [13:0] MDRIN  = 14'h0020;
    localparam logic [13:0] MDROUT = 14'h0010;
    localparam logic [13:0] IRIN   = 14'h0008;
    localparam logic [13:0] YIN    = 14'h0004;
    localparam logic [13:0] LOIN   = 14'h0002;
    localparam logic [13:0] HIIN   = 14'h0001;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    // clock / reset
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [W-1:0] v(input logic [13:0] s, input logic [4:0] alu,
                                       input logic [15:0] ro, input logic [15:0] ri,
                                       input logic run, input logic ill);
        return {s, alu, ro, ri, run, ill};
    endfunction

    function automatic logic [W-1:0] e_zero();
        return v(14'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    endfunction

    // driver tasks: inputs change 1 time unit after the rising edge; the
    // pushed word is what the outputs must show for the rest of that cycle
    task automatic cyc(input logic rst, input logic mr, input logic stp,
                       input logic [W-1:0] e, input string tag);
        Reset     = rst;
        Mem_ready = mr;
        Stop      = stp;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input int waits, input logic stp);
        cyc(1'b0, 1'b1, stp, v(PCOUT | MARIN | ZIN | INCPC, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "t0");
        repeat (waits) cyc(1'b0, 1'b0, stp, v(ZLOOUT | PCIN | READ | MDRIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "t1_wait");
        cyc(1'b0, 1'b1, stp, v(ZLOOUT | PCIN | READ | MDRIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "t1");
        cyc(1'b0, 1'b1, stp, v(MDROUT | IRIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "t2");
    endtask

    task automatic reset_pulse(input string tag);
        cyc(1'b1, 1'b1, 1'b0, e_zero(), tag);
        cyc(1'b0, 1'b1, 1'b0, e_zero(), "reset_release");
    endtask

    task automatic after_boundary();
`ifdef CU_SINGLE_STEP_EN
        step = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, v(14'h0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "pause_step");
        step = 1'b0;
`endif
    endtask

    // scoreboard monitor
    always @(negedge Clock) begin
        logic [W-1:0] act;
        logic [W-1:0] e;
        string        t;
        act = {PCout, MARin, Zin, ZLOout, ZHIout, PCin, IncrementPC, Read, MDRin,
               MDRout, IRin, Yin, LOin, HIin, ALUControl, Rout_sel, Rin_sel, Run, Illegal};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: actual %h required %h (t=%0t)", t, act, e, $time);
            end
        end
    end

    initial begin
        Reset     = 1'b1;
        IR        = 32'h0;
        Mem_ready = 1'b1;
        Stop      = 1'b0;
        step      = 1'b0;
        @(posedge Clock);
        #1;
        reset_pulse("reset_hold");

        // ADD-class op 00101: R1 <= R2 op R3, 6 cycles
        IR = 32'h28918000;
        fetch(0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, v(YIN, 5'd0, 16'h0004, 16'h0, 1'b1, 1'b0), "alu_t3");
        cyc(1'b0, 1'b1, 1'b0, v(ZIN, 5'b00101, 16'h0008, 16'h0, 1'b1, 1'b0), "alu_t4");
        cyc(1'b0, 1'b1, 1'b0, v(ZLOOUT, 5'd0, 16'h0, 16'h0002, 1'b1, 1'b0), "alu_t5");
        after_boundary();

        // highest ALU opcode, aliased sources, three T1 wait cycles
        IR = {5'd11, 4'd15, 4'd0, 4'd0, 15'd0};
        fetch(3, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, v(YIN, 5'd0, 16'h0001, 16'h0, 1'b1, 1'b0), "wait_t3");
        cyc(1'b0, 1'b1, 1'b0, v(ZIN, 5'd11, 16'h0001, 16'h0, 1'b1, 1'b0), "wait_t4");
        cyc(1'b0, 1'b1, 1'b0, v(ZLOOUT, 5'd0, 16'h0, 16'h8000, 1'b1, 1'b0), "wait_t5");
        after_boundary();

        // MUL
        IR = {5'd12, 4'd4, 4'd5, 4'd6, 15'd0};
        fetch(0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, v(YIN, 5'd0, 16'h0020, 16'h0, 1'b1, 1'b0), "mul_t3");
        cyc(1'b0, 1'b1, 1'b0, v(ZIN, 5'd12, 16'h0040, 16'h0, 1'b1, 1'b0), "mul_t4");
        cyc(1'b0, 1'b1, 1'b0, v(ZLOOUT | LOIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "mul_t5");
        cyc(1'b0, 1'b1, 1'b0, v(ZHIOUT | HIIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "mul_t6");
        after_boundary();

        // DIV with Stop held throughout: only the end of T6 counts
        IR = {5'd13, 4'd7, 4'd8, 4'd9, 15'd0};
        fetch(0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, v(YIN, 5'd0, 16'h0100, 16'h0, 1'b1, 1'b0), "div_t3");
        cyc(1'b0, 1'b1, 1'b1, v(ZIN, 5'd13, 16'h0200, 16'h0, 1'b1, 1'b0), "div_t4");
        cyc(1'b0, 1'b1, 1'b1, v(ZLOOUT | LOIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "div_t5");
        cyc(1'b0, 1'b1, 1'b1, v(ZHIOUT | HIIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "div_t6");
        cyc(1'b0, 1'b1, 1'b0, e_zero(), "div_halt");
        cyc(1'b0, 1'b0, 1'b0, e_zero(), "div_halt_hold");
        reset_pulse("reset_after_div");

        // reset in the middle of T4
        IR = 32'h28918000;
        fetch(0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, v(YIN, 5'd0, 16'h0004, 16'h0, 1'b1, 1'b0), "mid_t3");
        reset_pulse("reset_mid_t4");

        // undefined opcode: Illegal for one cycle, Stop ignored, back to T0
        IR = {5'd31, 4'd2, 4'd3, 4'd4, 15'd0};
        fetch(0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, v(YIN, 5'd0, 16'h0008, 16'h0, 1'b1, 1'b1), "illegal_t3");

        // HALT opcode
        IR = {5'd27, 4'd1, 4'd1, 4'd1, 15'd0};
        fetch(0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, v(YIN, 5'd0, 16'h0002, 16'h0, 1'b1, 1'b0), "halt_t3");
        cyc(1'b0, 1'b1, 1'b0, e_zero(), "halt_op_0");
        cyc(1'b0, 1'b0, 1'b1, e_zero(), "halt_op_1");
        cyc(1'b0, 1'b1, 1'b0, e_zero(), "halt_op_2");
        reset_pulse("reset_after_halt");

        // Stop at the end of an ALU op; Stop during fetch/T3/T4 ignored
        IR = {5'd0, 4'd5, 4'd5, 4'd5, 15'd0};
        fetch(1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, v(YIN, 5'd0, 16'h0020, 16'h0, 1'b1, 1'b0), "stop_t3");
        cyc(1'b0, 1'b1, 1'b1, v(ZIN, 5'd0, 16'h0020, 16'h0, 1'b1, 1'b0), "stop_t4");
        cyc(1'b0, 1'b1, 1'b1, v(ZLOOUT, 5'd0, 16'h0, 16'h0020, 1'b1, 1'b0), "stop_t5");
        cyc(1'b0, 1'b1, 1'b0, e_zero(), "stop_halt_0");
        cyc(1'b0, 1'b1, 1'b0, e_zero(), "stop_halt_1");
        reset_pulse("reset_after_stop");

`ifdef CU_SINGLE_STEP_EN
        // PAUSE waits for Step; Stop in PAUSE halts
        IR = 32'h28918000;
        fetch(0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, v(YIN, 5'd0, 16'h0004, 16'h0, 1'b1, 1'b0), "ss_t3");
        cyc(1'b0, 1'b1, 1'b0, v(ZIN, 5'b00101, 16'h0008, 16'h0, 1'b1, 1'b0), "ss_t4");
        cyc(1'b0, 1'b1, 1'b0, v(ZLOOUT, 5'd0, 16'h0, 16'h0002, 1'b1, 1'b0), "ss_t5");
        cyc(1'b0, 1'b1, 1'b0, v(14'h0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "ss_pause_0");
        cyc(1'b0, 1'b1, 1'b0, v(14'h0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "ss_pause_1");
        after_boundary();
        fetch(0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, v(YIN, 5'd0, 16'h0004, 16'h0, 1'b1, 1'b0), "ss2_t3");
        cyc(1'b0, 1'b1, 1'b0, v(ZIN, 5'b00101, 16'h0008, 16'h0, 1'b1, 1'b0), "ss2_t4");
        cyc(1'b0, 1'b1, 1'b0, v(ZLOOUT, 5'd0, 16'h0, 16'h0002, 1'b1, 1'b0), "ss2_t5");
        cyc(1'b0, 1'b1, 1'b1, v(14'h0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "ss2_pause_stop");
        cyc(1'b0, 1'b1, 1'b0, e_zero(), "ss2_halt");
        reset_pulse("reset_after_ss");
`endif

        cyc(1'b0, 1'b1, 1'b0, v(PCOUT | MARIN | ZIN | INCPC, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "final_t0");

        @(negedge Clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: actual %0d entries required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
